// File: rtl/instr_decode_ctrl.sv
// rtl/instr_decode_ctrl.sv - 16-bit instruction decoder and 3-state sequencer for the ALU datapath.
// Define PSR_LATCH_EN to latch ALU Flags into Psr on EXEC; otherwise Psr is tied to zero.
module instr_decode_ctrl #(
  parameter int IMM_W = 8,
  parameter int OP_W  = 5
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            InstrValid,
  output logic            InstrReady,
  input  logic [15:0]     Instr,
  input  logic [4:0]      Flags,
  output logic [3:0]      RdestRegLoc,
  output logic [3:0]      RsrcRegLoc,
  output logic [15:0]     Imm,
  output logic            Imm_s,
  output logic [OP_W-1:0] OpCode,
  output logic            En,
  output logic            Illegal,
  output logic [4:0]      Psr
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;
  state_t state;

  logic [IMM_W-1:0] immField;
  logic [3:0]       key;
  logic             immForm;
  logic             decLegal;
  logic             decCmp;
  logic             decNoFlags;
  logic [OP_W-1:0]  decOp;
  logic [15:0]      decImm;
  logic             enPending;

  // Immediate forms reuse the register-form opext encodings in the op field.
  always_comb begin
    immField   = Instr[IMM_W-1:0];
    immForm    = (Instr[15:12] != 4'b0000);
    key        = immForm ? Instr[15:12] : Instr[7:4];
    decLegal   = 1'b1;
    decCmp     = 1'b0;
    decNoFlags = 1'b0;
    decOp      = '0;
    decImm     = 16'($signed(immField));
    case (key)
      4'b0101: decOp = OP_W'(0);
      4'b1001: decOp = OP_W'(1);
      4'b1011: begin
        decOp  = OP_W'(2);
        decCmp = 1'b1;
      end
      4'b0001: begin
        decOp  = OP_W'(3);
        decImm = 16'(immField);
      end
      4'b0010: begin
        decOp  = OP_W'(4);
        decImm = 16'(immField);
      end
      4'b0011: begin
        decOp  = OP_W'(5);
        decImm = 16'(immField);
      end
      4'b1101: begin
        decOp      = OP_W'(6);
        decNoFlags = 1'b1;
      end
      4'b1111: begin
        if (immForm) begin
          decOp      = OP_W'(7);
          decImm     = 16'({immField, 8'h00});
          decNoFlags = 1'b1;
        end else begin
          decLegal = 1'b0;
        end
      end
      default: decLegal = 1'b0;
    endcase
  end

`ifdef PSR_LATCH_EN
  logic psrPending;
`else
  logic unusedFlags;
  assign unusedFlags = ^Flags;
  assign Psr = '0;
`endif

  // Decoded outputs are registered on the accept edge so they are stable for all of DECODE and EXEC.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      InstrReady  <= 1'b1;
      RdestRegLoc <= '0;
      RsrcRegLoc  <= '0;
      Imm         <= '0;
      Imm_s       <= 1'b0;
      OpCode      <= '0;
      En          <= 1'b0;
      Illegal     <= 1'b0;
      enPending   <= 1'b0;
`ifdef PSR_LATCH_EN
      psrPending  <= 1'b0;
      Psr         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          En <= 1'b0;
          if (InstrValid && InstrReady) begin
            InstrReady <= 1'b0;
            state      <= DECODE;
            if (decLegal) begin
              RdestRegLoc <= Instr[11:8];
              RsrcRegLoc  <= Instr[3:0];
              OpCode      <= decOp;
              Imm_s       <= immForm;
              if (immForm) Imm <= decImm;
              enPending   <= !decCmp;
            end else begin
              Illegal   <= 1'b1;
              enPending <= 1'b0;
            end
`ifdef PSR_LATCH_EN
            psrPending <= decLegal && !decNoFlags;
`endif
          end
        end
        DECODE: begin
          En    <= enPending;
          state <= EXEC;
        end
        EXEC: begin
          En         <= 1'b0;
          InstrReady <= 1'b1;
          state      <= IDLE;
`ifdef PSR_LATCH_EN
          if (psrPending) Psr <= Flags;
`endif
        end
        default: begin
          En         <= 1'b0;
          InstrReady <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb/tb_instr_decode_ctrl.sv - scoreboard bench for instr_decode_ctrl (honours PSR_LATCH_EN).
module tb_instr_decode_ctrl;

  logic        Clk;
  logic        Rst;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] Instr;
  logic [4:0]  Flags;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [4:0]  OpCode;
  logic        En;
  logic        Illegal;
  logic [4:0]  Psr;

  instr_decode_ctrl dut (
    .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .Flags(Flags), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
    .Imm(Imm), .Imm_s(Imm_s), .OpCode(OpCode), .En(En), .Illegal(Illegal), .Psr(Psr)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        imms;
    logic [4:0]  op;
    logic        en;
    logic        chk;
    logic        chkImm;
    logic        ill;
    logic [4:0]  psr;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ph = 0;
  bit   sawReset = 0;
  logic [4:0] psrModel = '0;
  logic       illModel = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: follows each accepted instruction through DECODE/EXEC/return-to-IDLE.
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst) begin
        chk("rst_ready", InstrReady, 1);
        chk("rst_rdest", RdestRegLoc, 0);
        chk("rst_rsrc", RsrcRegLoc, 0);
        chk("rst_imm", Imm, 0);
        chk("rst_imms", Imm_s, 0);
        chk("rst_op", OpCode, 0);
        chk("rst_en", En, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_psr", Psr, 0);
        ph = 0;
        sawReset = 1;
      end else begin
        if (sawReset) begin
          chk("ready_after_rst", InstrReady, 1);
          sawReset = 0;
        end
        case (ph)
          1: begin
            if (cur.chk) begin
              chk("dec_rdest", RdestRegLoc, cur.rd);
              chk("dec_rsrc", RsrcRegLoc, cur.rs);
              chk("dec_op", OpCode, cur.op);
              chk("dec_imms", Imm_s, cur.imms);
              if (cur.chkImm) chk("dec_imm", Imm, cur.imm);
            end
            chk("decode_en", En, 0);
            chk("decode_ready", InstrReady, 0);
            ph = 2;
          end
          2: begin
            chk("exec_en", En, cur.en);
            chk("exec_ready", InstrReady, 0);
            ph = 3;
          end
          3: begin
            chk("done_ready", InstrReady, 1);
            chk("done_illegal", Illegal, cur.ill);
            chk("done_psr", Psr, cur.psr);
            chk("done_en", En, 0);
            ph = 0;
          end
          default: if (En !== 1'b0) chk("idle_en", En, 0);
        endcase
        if (ph == 0 && InstrValid && InstrReady) begin
          if (expQ.size() == 0) begin
            chk("unexpected_accept", 1, 0);
            cur = '0;
          end else begin
            cur = expQ.pop_front();
          end
          ph = 1;
        end
      end
    end
  end

  task automatic send(input logic [15:0] ins, input logic [4:0] fl, input logic legal,
                      input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm,
                      input logic imms, input logic [4:0] op, input logic en,
                      input logic chkImm, input logic latch, output int accCyc);
    exp_t e;
    bit got = 0;
    illModel = illModel | !legal;
`ifdef PSR_LATCH_EN
    if (legal && latch) psrModel = fl;
`endif
    e = '{rd: rd, rs: rs, imm: imm, imms: imms, op: op, en: en, chk: legal,
          chkImm: chkImm, ill: illModel, psr: psrModel};
    expQ.push_back(e);
    Instr = ins;
    Flags = fl;
    InstrValid = 1'b1;
    accCyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (InstrReady) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    accCyc = cyc;
    @(posedge Clk);
    #2;
  endtask

  task automatic drain();
    InstrValid = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
  endtask

  int a0, a1, a2;

  initial begin
    Rst = 1'b1;
    InstrValid = 1'b0;
    Instr = '0;
    Flags = '0;
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    @(posedge Clk);
    #2;

    // ADD R1,R2 aborted by reset during DECODE
    send(16'h0152, 5'b00011, 1, 4'd1, 4'd2, 16'h0, 0, 5'd0, 1, 0, 1, a0);
    Rst = 1'b1;
    InstrValid = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    psrModel = '0;
    illModel = 1'b0;
    @(posedge Clk);
    #2;

    send(16'h0152, 5'b00011, 1, 4'd1, 4'd2, 16'h0000, 0, 5'd0, 1, 0, 1, a0);
    drain();
    send(16'h53FF, 5'b00100, 1, 4'd3, 4'd15, 16'hFFFF, 1, 5'd0, 1, 1, 1, a0);
    drain();
    send(16'h13FF, 5'b01000, 1, 4'd3, 4'd15, 16'h00FF, 1, 5'd3, 1, 1, 1, a0);
    drain();
    send(16'hF412, 5'b11111, 1, 4'd4, 4'd2, 16'h1200, 1, 5'd7, 1, 1, 0, a0);
    drain();
    send(16'h05B6, 5'b10101, 1, 4'd5, 4'd6, 16'h0000, 0, 5'd2, 0, 0, 1, a0);
    drain();
    send(16'h0F00, 5'b00110, 0, 4'd0, 4'd0, 16'h0000, 0, 5'd0, 0, 0, 0, a0);
    drain();
    send(16'h0152, 5'b00001, 1, 4'd1, 4'd2, 16'h0000, 0, 5'd0, 1, 0, 1, a0);
    drain();

    // Back-to-back with InstrValid held: SUB R7,R2; ORI R10,0x80; MOVI R11,-16
    send(16'h0792, 5'b01010, 1, 4'd7, 4'd2, 16'h0000, 0, 5'd1, 1, 0, 1, a0);
    send(16'h2A80, 5'b01010, 1, 4'd10, 4'd0, 16'h0080, 1, 5'd4, 1, 1, 1, a1);
    send(16'hDBF0, 5'b01010, 1, 4'd11, 4'd0, 16'hFFF0, 1, 5'd6, 1, 1, 0, a2);
    drain();
    chk("b2b_gap1", a1 - a0, 3);
    chk("b2b_gap2", a2 - a1, 3);
    chk("queue_empty", expQ.size(), 0);
    chk("monitor_idle", ph, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
